mips_register_mem: RTL and testbench



---
 rtl/mips_register_mem_if.sv | 27 ++
 rtl/mips_register_mem.sv | 43 ++++
 tb/tb_mips_register_mem.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mips_register_mem_if.sv
// Register-file access bus.
// Carries two read address/data pairs and one write port
// (address, data, enable) between a pipeline stage and the register file.
//   master : drives r_reg1/r_reg2/w_reg_addr/w_data/reg_w, receives r_data1/r_data2
//   slave  : the register file itself
interface mips_register_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] r_reg1;
    logic [ADDR_W-1:0] r_reg2;
    logic [ADDR_W-1:0] w_reg_addr;
    logic [DATA_W-1:0] w_data;
    logic              reg_w;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;

    modport master (
        output r_reg1, r_reg2, w_reg_addr, w_data, reg_w,
        input  r_data1, r_data2
    );

    modport slave (
        input  r_reg1, r_reg2, w_reg_addr, w_data, reg_w,
        output r_data1, r_data2
    );
endinterface

// File: rtl/mips_register_mem.sv
// MIPS-style general-purpose register file: 2**ADDR_W x DATA_W registers,
// two combinational read ports and one write port that updates on the rising clock edge.
// With ZERO_R0=1, register 0 reads as zero and writes to it are dropped.
// Ports:
//   clk  : clock; writes take effect on its rising edge
//   clr  : asynchronous active-high clear of every register (overrides writes)
//   bus  : slave side of mips_register_mem_if (read addrs/data, write port)
module mips_register_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic                clk,
    input  logic                clr,
    mips_register_mem_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;

    // A write to R0 is discarded at the source, so R0 stays at its cleared value.
    assign wr_en = bus.reg_w && !((ZERO_R0 != 0) && (bus.w_reg_addr == '0));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.w_reg_addr] <= bus.w_data;
        end
    end

    // No write bypass: a read of the address being written returns the old
    // contents until the edge, then the new contents straight after it.
    always_comb begin
        bus.r_data1 = regs[bus.r_reg1];
        bus.r_data2 = regs[bus.r_reg2];
        if ((ZERO_R0 != 0) && (bus.r_reg1 == '0)) bus.r_data1 = '0;
        if ((ZERO_R0 != 0) && (bus.r_reg2 == '0)) bus.r_data2 = '0;
    end
endmodule

// File: tb/tb_mips_register_mem.sv
// Testbench for mips_register_mem: directed cases followed by randomized
// write/read traffic checked against an array-based reference model.
module tb_mips_register_mem;
    logic clk;
    logic clr;
    int   tests = 0;
    int   fails = 0;

    mips_register_mem_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mips_register_mem #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain array; R0 always reads zero.
    logic [31:0] mdl [32];

    function automatic logic [31:0] mread(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mdl[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    endtask

    // Drive a write at the falling edge, let the rising edge take it.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
        @(negedge clk);
        bus.w_reg_addr = a;
        bus.w_data     = d;
        bus.reg_w      = en;
        @(posedge clk);
        #1;
        if (!clr && en && a != 5'd0) mdl[a] = d;
        bus.reg_w = 1'b0;
    endtask

    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd;
    logic        we;

    initial begin
        bus.r_reg1 = '0; bus.r_reg2 = '0; bus.w_reg_addr = '0;
        bus.w_data = '0; bus.reg_w = 1'b0;
        model_clear();

        // 1) clear pulse, reads of 1 and 31 are zero during and after clr
        clr = 1'b1;
        #3;
        bus.r_reg1 = 5'd1; bus.r_reg2 = 5'd31;
        #1;
        check("rst_rd1_during", bus.r_data1, 32'd0);
        check("rst_rd2_during", bus.r_data2, 32'd0);
        @(negedge clk); clr = 1'b0;
        #1;
        check("rst_rd1_after", bus.r_data1, 32'd0);
        check("rst_rd2_after", bus.r_data2, 32'd0);

        // 2) write 1256 to reg 1, read on both ports
        wr(5'd1, 32'd1256, 1'b1);
        bus.r_reg1 = 5'd1; bus.r_reg2 = 5'd1;
        #1;
        check("wr1_rd1", bus.r_data1, 32'd1256);
        check("wr1_rd2", bus.r_data2, 32'd1256);

        // 3) write 1256 to reg 15, reg 1 unaffected
        wr(5'd15, 32'd1256, 1'b1);
        bus.r_reg1 = 5'd1; bus.r_reg2 = 5'd15;
        #1;
        check("wr15_rd15", bus.r_data2, 32'd1256);
        check("wr15_reg1", bus.r_data1, 32'd1256);

        // 4) write to R0 is discarded
        wr(5'd0, 32'hFFFF_FFFF, 1'b1);
        bus.r_reg1 = 5'd0; bus.r_reg2 = 5'd0;
        #1;
        check("r0_rd1", bus.r_data1, 32'd0);
        check("r0_rd2", bus.r_data2, 32'd0);

        // 5) reg_w=0 leaves reg 2 untouched
        wr(5'd2, 32'd77, 1'b0);
        bus.r_reg1 = 5'd2;
        #1;
        check("noen_reg2", bus.r_data1, 32'd0);

        // Read-during-write on the same address: old value before, new right after the edge
        @(negedge clk);
        bus.w_reg_addr = 5'd7; bus.w_data = 32'hCAFE_0007; bus.reg_w = 1'b1;
        bus.r_reg1 = 5'd7; bus.r_reg2 = 5'd7;
        #1;
        check("rdw_old1", bus.r_data1, 32'd0);
        check("rdw_old2", bus.r_data2, 32'd0);
        @(posedge clk); #1;
        mdl[7] = 32'hCAFE_0007;
        bus.reg_w = 1'b0;
        check("rdw_new1", bus.r_data1, 32'hCAFE_0007);
        check("rdw_new2", bus.r_data2, 32'hCAFE_0007);

        // 6) mid-cycle clr drops regs 1/15 immediately; write under clr ignored
        @(negedge clk);
        bus.r_reg1 = 5'd1; bus.r_reg2 = 5'd15;
        #1;
        check("pre_clr_rd1", bus.r_data1, 32'd1256);
        check("pre_clr_rd2", bus.r_data2, 32'd1256);
        #1;
        clr = 1'b1;
        model_clear();
        #1;
        check("midclr_rd1", bus.r_data1, 32'd0);
        check("midclr_rd2", bus.r_data2, 32'd0);
        wr(5'd3, 32'd999, 1'b1);
        bus.r_reg1 = 5'd3;
        #1;
        check("clr_blocks_wr", bus.r_data1, 32'd0);
        @(negedge clk); clr = 1'b0;
        #1;
        check("post_clr_reg15", bus.r_data2, 32'd0);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            clr = 1'b0;
            wa  = 5'($urandom);
            wd  = $urandom;
            we  = ($urandom_range(0, 3) != 0);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            ra2 = 5'($urandom);
            bus.w_reg_addr = wa; bus.w_data = wd; bus.reg_w = we;
            bus.r_reg1 = ra1; bus.r_reg2 = ra2;
            #1;
            check("rnd_pre_rd1", bus.r_data1, mread(ra1));
            check("rnd_pre_rd2", bus.r_data2, mread(ra2));
            if ($urandom_range(0, 39) == 0) begin
                clr = 1'b1;
                model_clear();
                #1;
                check("rnd_clr_rd1", bus.r_data1, 32'd0);
                check("rnd_clr_rd2", bus.r_data2, 32'd0);
            end
            @(posedge clk); #1;
            if (!clr && we && wa != 5'd0) mdl[wa] = wd;
            check("rnd_post_rd1", bus.r_data1, mread(ra1));
            check("rnd_post_rd2", bus.r_data2, mread(ra2));
        end

        // Sweep every address through port 2 after the random run
        @(negedge clk);
        clr = 1'b0; bus.reg_w = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.r_reg2 = 5'(a);
            #1;
            check("sweep_rd2", bus.r_data2, mread(5'(a)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule
